// File: rtl/div5_word_serializer.sv
// ---------------------------------------------------------------------------
// div5_word_serializer
//
// Upstream feeder for a serial divisible-by-5 checker FSM. A parallel word is
// accepted over a valid/ready handshake. The checker is then cleared for one
// cycle. The word is shifted out MSB-first, one bit per clock. After CHK_LAT
// cycles the checker's flag is sampled, and one result is reported per word.
//
// Timing, counted from the edge that accepts the word (edge 0):
//   cycle 1                      CLR   : ser_clr_n = 0
//   cycles 2 .. WIDTH+1          SHIFT : ser_dout = word bit WIDTH-1-k in cycle 2+k
//   cycles WIDTH+2 .. +CHK_LAT   WAIT  : checker output settles
//   cycle WIDTH+2+CHK_LAT        IDLE  : res_valid pulse; a new word may be accepted
//
// Parameters:
//   WIDTH    word width in bits, legal range 2..32
//   CHK_LAT  cycles from the last serial bit to a valid chk_in, legal range 0..3
//            (1 matches a registered/Moore checker, 0 a combinational/Mealy one)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   word offered on in_data
//   in_ready   out  block can accept a word this cycle (state is IDLE)
//   in_data    in   [WIDTH-1:0] word to test, unsigned
//   ser_dout   out  serial bit to the checker's din, registered
//   ser_clr_n  out  active-low clear to the checker, registered
//   chk_in     in   checker's divisible flag
//   res_valid  out  one-cycle pulse: res_div5 / res_data valid
//   res_div5   out  1 = word divisible by 5
//   res_data   out  [WIDTH-1:0] word that was tested
//   busy       out  a word is in flight (state is not IDLE)
// ---------------------------------------------------------------------------
module div5_word_serializer #(
   parameter int WIDTH   = 8,
   parameter int CHK_LAT = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             ser_dout,
   output logic             ser_clr_n,
   input  logic             chk_in,
   output logic             res_valid,
   output logic             res_div5,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);

   // Bit counter only has to hold WIDTH-1 .. 0, so it never wraps in a word.
   localparam int CW = $clog2(WIDTH);

   // WAIT runs CHK_LAT cycles: load CHK_LAT-1 and leave when it reaches zero.
   localparam logic [1:0] WCNT_INIT = (CHK_LAT > 0) ? 2'(CHK_LAT - 1) : 2'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLR,
      S_SHIFT,
      S_WAIT
   } state_t;

   // Registered state and datapath.
   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic [1:0]       wcnt;

   // Next-state values computed combinationally.
   state_t           state_nx;
   logic [WIDTH-1:0] sr_nx;
   logic [CW-1:0]    cnt_nx;
   logic [1:0]       wcnt_nx;
   logic             ser_dout_nx;
   logic             ser_clr_n_nx;
   logic             res_valid_nx;
   logic             res_div5_nx;
   logic [WIDTH-1:0] res_data_nx;

   // Handshake and status decode from state only, never from in_valid.
   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);

   // ------------------------------------------------------------------------
   // Next-state and next-output logic.
   // ser_dout / ser_clr_n / res_* are registers. Their next values are chosen
   // here for the state the FSM enters, so each output lines up with the cycle
   // in which that state is current.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // forgot one would infer a latch instead of combinational logic.
      state_nx     = state;
      sr_nx        = sr;
      cnt_nx       = cnt;
      wcnt_nx      = wcnt;
      ser_dout_nx  = 1'b0;
      ser_clr_n_nx = 1'b1;
      res_valid_nx = 1'b0;
      res_div5_nx  = res_div5;
      res_data_nx  = res_data;

      unique case (state)
         S_IDLE: begin
            if (in_valid) begin
               // Accept: the checker sees its clear in the following cycle.
               state_nx     = S_CLR;
               sr_nx        = in_data;
               res_data_nx  = in_data;
               ser_clr_n_nx = 1'b0;
            end
         end

         S_CLR: begin
            // Present the MSB in the first SHIFT cycle.
            state_nx    = S_SHIFT;
            cnt_nx      = CW'(WIDTH - 1);
            ser_dout_nx = sr[WIDTH-1];
            sr_nx       = {sr[WIDTH-2:0], 1'b0};
         end

         S_SHIFT: begin
            if (cnt != '0) begin
               cnt_nx      = cnt - CW'(1);
               ser_dout_nx = sr[WIDTH-1];
               sr_nx       = {sr[WIDTH-2:0], 1'b0};
            end else if (CHK_LAT > 0) begin
               // Last bit is on the wire now; give the checker time to settle.
               state_nx = S_WAIT;
               wcnt_nx  = WCNT_INIT;
            end else begin
               // Combinational checker: its flag already reflects the last bit.
               state_nx     = S_IDLE;
               res_valid_nx = 1'b1;
               res_div5_nx  = chk_in;
            end
         end

         S_WAIT: begin
            if (wcnt != 2'd0) begin
               wcnt_nx = wcnt - 2'd1;
            end else begin
               state_nx     = S_IDLE;
               res_valid_nx = 1'b1;
               res_div5_nx  = chk_in;
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers. Reset aborts any word in flight and holds
   // the checker cleared until the first clock after release.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         sr        <= '0;
         cnt       <= '0;
         wcnt      <= 2'd0;
         ser_dout  <= 1'b0;
         ser_clr_n <= 1'b0;
         res_valid <= 1'b0;
         res_div5  <= 1'b0;
         res_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state     <= state_nx;
         sr        <= sr_nx;
         cnt       <= cnt_nx;
         wcnt      <= wcnt_nx;
         ser_dout  <= ser_dout_nx;
         ser_clr_n <= ser_clr_n_nx;
         res_valid <= res_valid_nx;
         res_div5  <= res_div5_nx;
         res_data  <= res_data_nx;
      end
   end

endmodule

// File: tb/tb_div5_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_div5_word_serializer
//
// Directed bench for div5_word_serializer.
//   u_dut  : WIDTH=8, CHK_LAT=1, driving a registered (Moore) checker model.
//   u_dut0 : WIDTH=8, CHK_LAT=0, driving a combinational (Mealy) checker model.
// Inputs are driven on the falling edge, and outputs are sampled there too.
// The n-th falling edge after the accepting rising edge lies in cycle n.
// ---------------------------------------------------------------------------
module tb_div5_word_serializer;

   logic       clk = 1'b0;
   logic       reset_n;

   // CHK_LAT=1 instance
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       ser_dout;
   logic       ser_clr_n;
   logic       chk_in;
   logic       res_valid;
   logic       res_div5;
   logic [7:0] res_data;
   logic       busy;

   // CHK_LAT=0 instance
   logic       in_valid0;
   logic       in_ready0;
   logic [7:0] in_data0;
   logic       ser_dout0;
   logic       ser_clr_n0;
   logic       chk_in0;
   logic       res_valid0;
   logic       res_div50;
   logic [7:0] res_data0;
   logic       busy0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div5_word_serializer #(.WIDTH(8), .CHK_LAT(1)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .ser_dout  (ser_dout),
      .ser_clr_n (ser_clr_n),
      .chk_in    (chk_in),
      .res_valid (res_valid),
      .res_div5  (res_div5),
      .res_data  (res_data),
      .busy      (busy)
   );

   div5_word_serializer #(.WIDTH(8), .CHK_LAT(0)) u_dut0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid0),
      .in_ready  (in_ready0),
      .in_data   (in_data0),
      .ser_dout  (ser_dout0),
      .ser_clr_n (ser_clr_n0),
      .chk_in    (chk_in0),
      .res_valid (res_valid0),
      .res_div5  (res_div50),
      .res_data  (res_data0),
      .busy      (busy0)
   );

   // Checker models: remainder mod 5 of the bits seen so far, cleared by clr_n.
   logic [2:0] rem1;
   logic [2:0] rem0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        rem1 <= 3'd0;
      else if (!ser_clr_n) rem1 <= 3'd0;
      else                 rem1 <= 3'((int'(rem1) * 2 + int'(ser_dout)) % 5);
   end
   assign chk_in = (rem1 == 3'd0);   // Moore: decoded from the register

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         rem0 <= 3'd0;
      else if (!ser_clr_n0) rem0 <= 3'd0;
      else                  rem0 <= 3'((int'(rem0) * 2 + int'(ser_dout0)) % 5);
   end
   assign chk_in0 = (((int'(rem0) * 2 + int'(ser_dout0)) % 5) == 0);  // Mealy

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   task automatic test_reset();
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_valid0 = 1'b0;
      in_data0  = 8'h00;
      #3;
      checks++; if (ser_clr_n !== 1'b0) begin errors++; $display("FAIL reset_ser_clr_n got=%b exp=0", ser_clr_n); end
      checks++; if (ser_dout  !== 1'b0) begin errors++; $display("FAIL reset_ser_dout got=%b exp=0", ser_dout); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
      checks++; if (res_data  !== 8'h00) begin errors++; $display("FAIL reset_res_data got=%h exp=00", res_data); end
      checks++; if (busy      !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready  !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
      checks++; if (ser_clr_n !== 1'b1) begin errors++; $display("FAIL idle_ser_clr_n got=%b exp=1", ser_clr_n); end
   endtask

   // 0x0A with full cycle-by-cycle check of the serial stream and result.
   task automatic test_first_word();
      logic [7:0] bits;
      bits = 8'b0000_1010;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h0A;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) begin
            in_valid = 1'b0;
            checks++; if (ser_clr_n !== 1'b0) begin errors++; $display("FAIL clr_cycle1 got=%b exp=0", ser_clr_n); end
            checks++; if (ser_dout  !== 1'b0) begin errors++; $display("FAIL dout_cycle1 got=%b exp=0", ser_dout); end
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL busy_cycle1 busy=%b ready=%b exp 1/0", busy, in_ready); end
         end else if (c <= 9) begin
            checks++; if (ser_dout !== bits[9-c]) begin errors++; $display("FAIL dout_cycle%0d got=%b exp=%b", c, ser_dout, bits[9-c]); end
            checks++; if (ser_clr_n !== 1'b1) begin errors++; $display("FAIL clr_cycle%0d got=%b exp=1", c, ser_clr_n); end
         end else if (c == 10) begin
            checks++; if (res_valid !== 1'b0 || ser_dout !== 1'b0) begin errors++; $display("FAIL wait_cycle10 res_valid=%b dout=%b exp 0/0", res_valid, ser_dout); end
         end else if (c == 11) begin
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL res_valid_cycle11 got=%b exp=1", res_valid); end
            checks++; if (res_div5 !== 1'b1 || res_data !== 8'h0A) begin errors++; $display("FAIL result_0a div5=%b data=%h exp 1/0a", res_div5, res_data); end
            checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_cycle11 busy=%b ready=%b exp 0/1", busy, in_ready); end
         end else begin
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL res_valid_cycle12 got=%b exp=0", res_valid); end
         end
      end
   endtask

   // One word, expecting exactly one pulse, in cycle 11, with the given flag.
   task automatic run_word(input logic [7:0] w, input logic exp_div5);
      int seen;
      int at;
      seen = 0;
      at   = 0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_before_%h got=%b exp=1", w, in_ready); end
      in_valid = 1'b1;
      in_data  = w;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
         if (res_valid === 1'b1) begin
            seen++;
            at = c;
            checks++;
            if (res_div5 !== exp_div5 || res_data !== w) begin
               errors++;
               $display("FAIL result_%h div5=%b data=%h exp %b/%h", w, res_div5, res_data, exp_div5, w);
            end
         end
      end
      checks++; if (seen != 1 || at != 11) begin errors++; $display("FAIL pulses_%h count=%0d at_cycle=%0d exp 1 at 11", w, seen, at); end
   endtask

   task automatic test_words();
      run_word(8'h07, 1'b0);
      run_word(8'hFE, 1'b0);
      run_word(8'h00, 1'b1);
      run_word(8'hFF, 1'b1);
   endtask

   // in_valid held with 0x0F while 0x0A is in flight.
   task automatic test_hold_valid();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h0A;
      @(posedge clk);
      for (int c = 1; c <= 23; c++) begin
         @(negedge clk);
         if (c == 1)  in_data  = 8'h0F;
         if (c <= 10) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_cycle%0d got=%b exp=0", c, in_ready); end
         end
         if (c == 11) begin
            checks++; if (res_valid !== 1'b1 || res_div5 !== 1'b1 || res_data !== 8'h0A) begin errors++; $display("FAIL hold_result_0a valid=%b div5=%b data=%h exp 1/1/0a", res_valid, res_div5, res_data); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_cycle11 got=%b exp=1", in_ready); end
         end
         if (c == 12) begin
            in_valid = 1'b0;
            checks++; if (busy !== 1'b1 || ser_clr_n !== 1'b0) begin errors++; $display("FAIL hold_accept_0f busy=%b clr_n=%b exp 1/0", busy, ser_clr_n); end
         end
         if (c == 22) begin
            checks++; if (res_valid !== 1'b1 || res_div5 !== 1'b1 || res_data !== 8'h0F) begin errors++; $display("FAIL hold_result_0f valid=%b div5=%b data=%h exp 1/1/0f", res_valid, res_div5, res_data); end
         end
         if (c == 23) begin
            checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL hold_no_requeue busy=%b valid=%b exp 0/0", busy, res_valid); end
         end
      end
   endtask

   // 0x05, 0x06, 0x19 back to back with in_valid held high.
   task automatic test_back_to_back();
      logic [7:0] exp_data [3];
      logic       exp_flag [3];
      int         idx;
      int         pulses;
      exp_data[0] = 8'h05; exp_flag[0] = 1'b1;
      exp_data[1] = 8'h06; exp_flag[1] = 1'b0;
      exp_data[2] = 8'h19; exp_flag[2] = 1'b1;
      pulses = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h05;
      @(posedge clk);
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         if (c == 1)  in_data  = 8'h06;
         if (c == 12) in_data  = 8'h19;
         if (c == 23) in_valid = 1'b0;
         if (c == 11 || c == 22 || c == 33) begin
            idx = c / 11 - 1;
            checks++;
            if (res_valid !== 1'b1 || res_div5 !== exp_flag[idx] || res_data !== exp_data[idx]) begin
               errors++;
               $display("FAIL b2b_result_%h valid=%b div5=%b data=%h exp 1/%b/%h",
                        exp_data[idx], res_valid, res_div5, res_data, exp_flag[idx], exp_data[idx]);
            end
         end
         if (res_valid === 1'b1) pulses++;
      end
      checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulse_count got=%0d exp=3", pulses); end
   endtask

   // Reset asserted in cycle 5 of a word.
   task automatic test_reset_mid();
      int seen;
      seen = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h0A;
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || ser_clr_n !== 1'b0 || ser_dout !== 1'b0) begin errors++; $display("FAIL midreset_ctl busy=%b clr_n=%b dout=%b exp 0/0/0", busy, ser_clr_n, ser_dout); end
      checks++; if (res_valid !== 1'b0 || res_div5 !== 1'b0 || res_data !== 8'h00) begin errors++; $display("FAIL midreset_res valid=%b div5=%b data=%h exp 0/0/00", res_valid, res_div5, res_data); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (res_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_result pulses=%0d busy=%b exp 0/0", seen, busy); end
      run_word(8'h14, 1'b1);
   endtask

   // CHK_LAT=0 instance with a Mealy checker: result in cycle 10.
   task automatic test_mealy();
      int seen;
      int at;
      seen = 0;
      at   = 0;
      @(negedge clk);
      in_valid0 = 1'b1;
      in_data0  = 8'h0A;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) in_valid0 = 1'b0;
         if (res_valid0 === 1'b1) begin
            seen++;
            at = c;
         end
         if (c == 10) begin
            checks++; if (res_valid0 !== 1'b1 || res_div50 !== 1'b1 || res_data0 !== 8'h0A) begin errors++; $display("FAIL mealy_result valid=%b div5=%b data=%h exp 1/1/0a", res_valid0, res_div50, res_data0); end
         end
      end
      checks++; if (seen != 1 || at != 10) begin errors++; $display("FAIL mealy_pulses count=%0d at_cycle=%0d exp 1 at 10", seen, at); end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      test_reset();
      test_first_word();
      test_words();
      test_hold_valid();
      test_back_to_back();
      test_reset_mid();
      test_mealy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
